i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 16: number of MSB-first bits captured per channel word.
REQ-002 Parameter SLOT_WIDTH, default 32: expected sclk periods per channel slot; legal range SAMPLE_WIDTH..62.
REQ-003 Port clk_74a, input, 1: the only clock; all logic is rising-edge clocked on it.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port audio_sclk, input, 1: serial bit clock as a level signal; period is at least 8 clk_74a cycles.
REQ-006 Port audio_lrck, input, 1: word select; 0 = left, 1 = right.
REQ-007 Port audio_adc, input, 1: serial data, MSB first, I2S-justified (one sclk after the lrck edge).
REQ-008 Port sample_left, output, SAMPLE_WIDTH: last complete left word.
REQ-009 Port sample_right, output, SAMPLE_WIDTH: last complete right word.
REQ-010 Port sample_valid, output, 1: one-cycle pulse when a new stereo pair is presented.
REQ-011 Port frame_err, output, 1: one-cycle pulse when a pair is discarded for a bad slot length.
REQ-012 Port locked, output, 1: high when the state is not SYNC.

Function
REQ-013 The block SHALL pass audio_sclk, audio_lrck and audio_adc each through a 2-flop synchronizer, then through one edge-detect register on sclk.
REQ-014 A "rise" SHALL be synchronized sclk high while its previous value was low; all protocol actions occur only in rise cycles.
REQ-015 On each rise, the block SHALL sample the synchronized lrck (lr) and data (d), and compare lr with lr_prev, the lr value from the previous rise.
REQ-016 Bit counter cnt is 6 bits. On a rise with lr == lr_prev, cnt SHALL increment, saturating at 63. On a rise with lr != lr_prev (a "boundary rise"), cnt SHALL load 0.
REQ-017 On every rise with cnt < SAMPLE_WIDTH, d SHALL shift into the capture register from the LSB side.
- The bit taken on a boundary rise belongs to the old word.
- The next rise carries the new word's MSB.
REQ-018 On a boundary rise, the old word's length SHALL be cnt+1, counting the current bit. A length equal to SLOT_WIDTH is good; any other length is bad.
REQ-019 State machine states are SYNC, LEFT and RIGHT. Transitions:
- SYNC -> LEFT on a boundary rise with lr_prev=1, lr=0; no data is output.
- LEFT -> RIGHT on a boundary rise with lr_prev=0, lr=1; the captured word is latched to the left holding register and left_bad is set if the length is bad.
- RIGHT -> LEFT on a boundary rise with lr_prev=1, lr=0; this completes the pair.
REQ-020 On pair completion with both slots good:
- sample_left SHALL take the left holding register value.
- sample_right SHALL take the captured word.
- sample_valid SHALL pulse in the cycle after the boundary rise.
REQ-021 On pair completion with either slot bad, sample_left and sample_right SHALL hold their values, frame_err SHALL pulse in the cycle after the boundary rise, and the state SHALL still go to LEFT.
REQ-022 The capture register SHALL clear to 0 on every boundary rise, after its value has been used.
REQ-023 sample_valid and frame_err SHALL never be high together, and neither SHALL be high for more than one cycle.
REQ-024 If lrck stops toggling, cnt saturates and no output is produced; the state SHALL be held until the next boundary rise.
REQ-025 Output latency SHALL be 4 clk_74a cycles from the sclk pin edge to the output pulse: 2 synchronizer, 1 edge detect, 1 output register.

Reset
REQ-026 While reset is high at a clock edge, the block SHALL set:
- state = SYNC, cnt = 0, lr_prev = 0
- capture register, left holding register and left_bad = 0
- sample_left = 0, sample_right = 0
- sample_valid = 0, frame_err = 0, locked = 0
REQ-027 The synchronizer and edge-detect flops SHALL reset to 0.
REQ-028 Reset asserted mid-word SHALL discard any partial pair; the block relocks only at the next lrck falling boundary.

Verification
REQ-029 Defaults, sclk = 8 clk periods: after one dummy right slot, drive left 0x1234 and right 0xABCD, each padded with 16 zeros -> one sample_valid pulse with sample_left=0x1234 and sample_right=0xABCD; no frame_err.
REQ-030 Lock: start streaming with lrck=1 from reset -> locked=0 and no output until the first 1->0 boundary; the first pair after that boundary is output correctly.
REQ-031 Bad slot: left slot 31 sclk long, right slot 32 -> frame_err pulse, sample_valid stays low, outputs keep their prior values; the following good pair 0x0001/0x8000 is output normally.
REQ-032 Reset mid-right-word: assert reset for 1 cycle -> all outputs 0 and locked=0 on the next cycle; no output for the interrupted pair.
REQ-033 Back-to-back: 100 consecutive good pairs with an incrementing pattern -> exactly 100 sample_valid pulses, values in order, and pulse spacing of 64 sclk periods.
REQ-034 Stuck lrck: hold lrck=0 for 200 sclk -> no pulses and locked stays 1; on resume, the first left slot is flagged bad and produces frame_err.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrck/adc on clk_74a, captures MSB-first
// channel words and presents complete stereo pairs with a slot-length check.
module i2s_rx #(
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned SLOT_WIDTH   = 32
) (
   input  logic                    clk_74a,
   input  logic                    reset,
   input  logic                    audio_sclk,
   input  logic                    audio_lrck,
   input  logic                    audio_adc,
   output logic [SAMPLE_WIDTH-1:0] sample_left,
   output logic [SAMPLE_WIDTH-1:0] sample_right,
   output logic                    sample_valid,
   output logic                    frame_err,
   output logic                    locked
);

   localparam int unsigned CW = 6;
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CAP_LIM  = CW'(SAMPLE_WIDTH);
   localparam logic [CW:0]   SLOT_LEN = (CW+1)'(SLOT_WIDTH);

   localparam logic [1:0] SYNC  = 2'd0;
   localparam logic [1:0] LEFT  = 2'd1;
   localparam logic [1:0] RIGHT = 2'd2;

   logic [1:0] sclk_sync, lrck_sync, adc_sync;
   logic       sclk_prev;
   logic       rise, lr, d;

   logic [1:0] state, state_next;
   logic [CW-1:0] cnt;
   logic          lr_prev;
   logic [SAMPLE_WIDTH-1:0] capture, left_hold, cap_shift;
   logic          left_bad;
   logic          boundary, left_done, pair_done, slot_bad;

   // Two-flop synchronizers plus a registered rise detect; lr/d stay aligned with rise
   always_ff @(posedge clk_74a) begin
      if (reset) begin
         sclk_sync <= '0;
         lrck_sync <= '0;
         adc_sync  <= '0;
         sclk_prev <= 1'b0;
         rise      <= 1'b0;
         lr        <= 1'b0;
         d         <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[0], audio_sclk};
         lrck_sync <= {lrck_sync[0], audio_lrck};
         adc_sync  <= {adc_sync[0], audio_adc};
         sclk_prev <= sclk_sync[1];
         rise      <= sclk_sync[1] & ~sclk_prev;
         lr        <= lrck_sync[1];
         d         <= adc_sync[1];
      end
   end

   // Next-state, word-boundary decode, shifted capture and slot-length check
   always_comb begin
      state_next = state;
      left_done  = 1'b0;
      pair_done  = 1'b0;
      boundary   = (lr != lr_prev);
      cap_shift  = capture;
      slot_bad   = (({1'b0, cnt} + (CW+1)'(1)) != SLOT_LEN);
      if (cnt < CAP_LIM) begin
         cap_shift = {capture[SAMPLE_WIDTH-2:0], d};
      end
      if (rise && boundary) begin
         case (state)
            SYNC:    if (!lr) state_next = LEFT;
            LEFT:    if (lr) begin
                        state_next = RIGHT;
                        left_done  = 1'b1;
                     end
            RIGHT:   if (!lr) begin
                        state_next = LEFT;
                        pair_done  = 1'b1;
                     end
            default: state_next = SYNC;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk_74a) begin
      if (reset) state <= SYNC;
      else       state <= state_next;
   end

   // Bit counter, capture/holding registers and registered outputs
   always_ff @(posedge clk_74a) begin
      if (reset) begin
         cnt          <= '0;
         lr_prev      <= 1'b0;
         capture      <= '0;
         left_hold    <= '0;
         left_bad     <= 1'b0;
         sample_left  <= '0;
         sample_right <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         locked       <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
         locked       <= (state_next != SYNC);
         if (rise) begin
            lr_prev <= lr;
            if (boundary) begin
               cnt     <= '0;
               capture <= '0;
            end else begin
               cnt     <= (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
               capture <= cap_shift;
            end
            if (left_done) begin
               left_hold <= cap_shift;
               left_bad  <= slot_bad;
            end
            if (pair_done) begin
               if (left_bad || slot_bad) begin
                  frame_err <= 1'b1;
               end else begin
                  sample_left  <= left_hold;
                  sample_right <= cap_shift;
                  sample_valid <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: lock, good pairs, bad slot, reset, streaming, stuck lrck.
module tb_i2s_rx;

   logic        clk_74a = 1'b0;
   logic        reset;
   logic        audio_sclk, audio_lrck, audio_adc;
   logic [15:0] sample_left, sample_right;
   logic        sample_valid, frame_err, locked;

   int checks = 0;
   int errors = 0;

   int valid_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0, spacing_bad = 0;
   logic prev_valid = 1'b0, prev_err = 1'b0;
   logic spacing_en = 1'b0, have_last = 1'b0;
   longint cyc = 0, last_cyc = 0;
   logic [31:0] q[$];

   i2s_rx dut (
      .clk_74a     (clk_74a),
      .reset       (reset),
      .audio_sclk  (audio_sclk),
      .audio_lrck  (audio_lrck),
      .audio_adc   (audio_adc),
      .sample_left (sample_left),
      .sample_right(sample_right),
      .sample_valid(sample_valid),
      .frame_err   (frame_err),
      .locked      (locked)
   );

   always #5 clk_74a = ~clk_74a;

   // Pulse monitor sampled on the falling edge
   always @(negedge clk_74a) begin
      cyc <= cyc + 1;
      if (sample_valid && frame_err) both_cnt <= both_cnt + 1;
      if ((sample_valid && prev_valid) || (frame_err && prev_err)) long_cnt <= long_cnt + 1;
      prev_valid <= sample_valid;
      prev_err   <= frame_err;
      if (frame_err) err_cnt <= err_cnt + 1;
      if (sample_valid) begin
         valid_cnt <= valid_cnt + 1;
         q.push_back({sample_left, sample_right});
         if (spacing_en) begin
            if (have_last && (cyc - last_cyc != 64'd512)) spacing_bad <= spacing_bad + 1;
            have_last <= 1'b1;
            last_cyc  <= cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sclk_bit(input logic lr, input logic b);
      @(negedge clk_74a);
      audio_sclk = 1'b0;
      audio_lrck = lr;
      audio_adc  = b;
      repeat (3) @(negedge clk_74a);
      audio_sclk = 1'b1;
      repeat (4) @(negedge clk_74a);
   endtask

   // One slot: bit 0 is the previous word's trailing bit, then 16 data bits MSB first, then zeros
   task automatic send_slot(input logic lr, input logic [15:0] word, input int len);
      logic b;
      for (int i = 0; i < len; i++) begin
         b = (i >= 1 && i <= 16) ? word[16-i] : 1'b0;
         sclk_bit(lr, b);
      end
   endtask

   task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
      send_slot(1'b0, l, 32);
      send_slot(1'b1, r, 32);
   endtask

   initial begin
      int vc0, ec0, qbase;
      audio_sclk = 1'b0;
      audio_lrck = 1'b1;
      audio_adc  = 1'b0;
      reset      = 1'b1;
      repeat (3) @(negedge clk_74a);
      check("rst_left",  32'(sample_left),  32'h0);
      check("rst_right", 32'(sample_right), 32'h0);
      check("rst_valid", 32'(sample_valid), 32'h0);
      check("rst_err",   32'(frame_err),    32'h0);
      check("rst_locked",32'(locked),       32'h0);
      reset = 1'b0;

      // Dummy right slot from reset: no lock yet
      send_slot(1'b1, 16'h0, 32);
      check("pre_lock_locked", 32'(locked), 32'h0);
      check("pre_lock_valid",  32'(valid_cnt), 32'd0);

      send_pair(16'h1234, 16'hABCD);
      check("lock_locked", 32'(locked), 32'h1);
      check("lock_no_out", 32'(valid_cnt), 32'd0);

      // Bad left slot (31) / good right; completes the 1234/ABCD pair on its first rise
      send_slot(1'b0, 16'h5555, 31);
      send_slot(1'b1, 16'h6666, 32);
      check("pair1_cnt",   32'(valid_cnt), 32'd1);
      check("pair1_left",  32'(sample_left),  32'h1234);
      check("pair1_right", 32'(sample_right), 32'hABCD);
      check("pair1_err",   32'(err_cnt), 32'd0);

      // Good pair completes the bad one
      spacing_en = 1'b1;
      qbase = q.size();
      send_pair(16'h0001, 16'h8000);
      check("bad_err",   32'(err_cnt), 32'd1);
      check("bad_valid", 32'(valid_cnt), 32'd1);
      check("bad_left",  32'(sample_left),  32'h1234);
      check("bad_right", 32'(sample_right), 32'hABCD);

      // Back-to-back stream
      for (int i = 0; i < 100; i++) send_pair(16'h0100 + 16'(i), 16'hF000 + 16'(i));
      send_slot(1'b0, 16'h0, 32);
      spacing_en = 1'b0;
      check("b2b_count", 32'(q.size() - qbase), 32'd101);
      check("b2b_first", q[qbase], 32'h0001_8000);
      for (int i = 0; i < 100; i++)
         check("b2b_value", q[qbase+1+i], {16'h0100 + 16'(i), 16'hF000 + 16'(i)});
      check("b2b_spacing", 32'(spacing_bad), 32'd0);
      check("b2b_err", 32'(err_cnt), 32'd1);

      // Reset in the middle of a right word
      send_slot(1'b1, 16'hFFFF, 10);
      vc0 = valid_cnt;
      ec0 = err_cnt;
      @(negedge clk_74a);
      reset = 1'b1;
      @(negedge clk_74a);
      reset = 1'b0;
      check("mid_rst_left",   32'(sample_left),  32'h0);
      check("mid_rst_right",  32'(sample_right), 32'h0);
      check("mid_rst_valid",  32'(sample_valid), 32'h0);
      check("mid_rst_err",    32'(frame_err),    32'h0);
      check("mid_rst_locked", 32'(locked),       32'h0);
      send_slot(1'b1, 16'h0, 22);
      check("relock_wait", 32'(locked), 32'h0);
      send_pair(16'hA5A5, 16'h5A5A);
      check("relock_locked", 32'(locked), 32'h1);
      check("relock_no_valid", 32'(valid_cnt), 32'(vc0));
      check("relock_no_err",   32'(err_cnt),   32'(ec0));

      // Stuck lrck low for 200 sclk; first rise completes A5A5/5A5A
      send_slot(1'b0, 16'h0, 200);
      check("stuck_valid", 32'(valid_cnt), 32'(vc0 + 1));
      check("stuck_left",  32'(sample_left),  32'hA5A5);
      check("stuck_right", 32'(sample_right), 32'h5A5A);
      check("stuck_err",   32'(err_cnt), 32'(ec0));
      check("stuck_locked",32'(locked), 32'h1);
      send_slot(1'b1, 16'h7777, 32);
      send_pair(16'h1357, 16'h2468);
      check("resume_err",   32'(err_cnt), 32'(ec0 + 1));
      check("resume_valid", 32'(valid_cnt), 32'(vc0 + 1));
      check("resume_left",  32'(sample_left), 32'hA5A5);
      send_slot(1'b0, 16'h0, 32);
      check("recover_valid", 32'(valid_cnt), 32'(vc0 + 2));
      check("recover_left",  32'(sample_left),  32'h1357);
      check("recover_right", 32'(sample_right), 32'h2468);

      check("pulse_overlap", 32'(both_cnt), 32'd0);
      check("pulse_width",   32'(long_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
